reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_SRC, default 2, number of asynchronous reset request sources (1..8).
REQ-002 Parameter NUM_OUT, default 4, number of sequenced reset outputs (1..8).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flop depth per source (>=2).
REQ-004 Parameter HOLD_CYCLES, default 4, consecutive quiet cycles required before release begins (>=1).
REQ-005 Parameter GAP_CYCLES, default 2, cycles between successive output releases (>=1).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high block reset.
REQ-008 reset_async_n  input  NUM_SRC  asynchronous active-low reset requests, any phase and pulse width.
REQ-009 cause_clr  input  1  synchronous clear of the cause register.
REQ-010 reset_sync_n  output  NUM_OUT  synchronized active-low resets; bit 0 releases first.
REQ-011 busy  output  1  high while any reset_sync_n bit is low.
REQ-012 cause  output  NUM_SRC  sticky record of which sources requested reset.

Function
REQ-013 Each reset_async_n bit SHALL pass through its own SYNC_STAGES-flop chain; chain flops SHALL be the only logic touching the raw inputs.
REQ-014 Request req SHALL be high when any synchronized bit is low.
REQ-015 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN; all outputs SHALL be registered.
REQ-016 ASSERT: all reset_sync_n = 0, busy = 1; go to HOLD on first cycle req = 0, with hold counter = 0.
REQ-017 HOLD: counter increments each req = 0 cycle; after HOLD_CYCLES cycles go to RELEASE and release bit 0.
REQ-018 RELEASE: each further bit i SHALL release exactly GAP_CYCLES cycles after bit i-1; once bit NUM_OUT-1 releases, go to RUN.
REQ-019 RUN: all reset_sync_n = 1, busy = 0.
REQ-020 req = 1 in HOLD, RELEASE or RUN SHALL return to ASSERT on the next edge, driving all outputs low and clearing all counters.
REQ-021 Assertion latency: all reset_sync_n SHALL be low SYNC_STAGES+1 edges after the first edge that samples any input low.
REQ-022 Release latency: bit 0 SHALL go high SYNC_STAGES+HOLD_CYCLES+1 edges after the first edge that samples all inputs high; bit i SHALL follow at +i*GAP_CYCLES.
REQ-023 A low pulse sampled by at least one edge SHALL produce a complete assert/release sequence; pulses sampled by no edge MAY be ignored.
REQ-024 A released output SHALL never re-assert except via ASSERT, which asserts all bits in the same cycle.
REQ-025 cause[j] SHALL set on any cycle synchronized source j is low and reset = 0; it SHALL clear only on cause_clr; set wins over simultaneous cause_clr.
REQ-026 Counters SHALL be sized by $clog2 of their parameter and SHALL not wrap.

Reset
REQ-027 reset = 1 at an edge SHALL load all sync flops with 0 (request asserted), state ASSERT, reset_sync_n = 0, busy = 1, counters = 0, cause = 0.
REQ-028 reset = 1 mid-sequence SHALL abort the sequence at the next edge; on reset deassertion the normal release sequence SHALL run per REQ-022.
REQ-029 While reset = 1, cause SHALL not set.

Verification (defaults: NUM_SRC=2, NUM_OUT=4, SYNC_STAGES=2, HOLD=4, GAP=2)
REQ-030 Power-up: reset 1 for 3 cycles, then reset 0 with inputs high -> reset_sync_n 0000 until release; then bits 0..3 high at edges 7, 9, 11, 13 after inputs sampled high; busy drops with bit 3.
REQ-031 From RUN, drive reset_async_n[1] low mid-cycle for 1 ns spanning an edge -> all outputs 0 three edges later; cause = 2'b10; full release sequence follows.
REQ-032 Input returns low during HOLD (after 2 quiet cycles) -> stays ASSERT, counter restarts; release timing measured from the final rising input.
REQ-033 Source 0 goes low after bit 1 released, before bit 2 -> bits 0..1 drop to 0 together on the same edge; bits 2..3 never pulse high.
REQ-034 cause_clr asserted while source 0 still low -> cause[0] remains 1; asserted after release -> cause = 00 next edge.
REQ-035 reset = 1 asserted during RELEASE -> all outputs 0 and cause 00 next edge; after reset drops, release at edges 7/9/11/13 again.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Collects asynchronous active-low reset requests, synchronizes each one,
//   and produces a set of synchronous active-low resets. All outputs assert
//   together; once every request has been quiet for HOLD_CYCLES cycles the
//   outputs release one at a time, bit 0 first, GAP_CYCLES cycles apart.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : synchronous active-high block reset
//   reset_async_n  : [NUM_SRC] asynchronous active-low reset requests
//   cause_clr      : synchronous clear of the cause register
//   reset_sync_n   : [NUM_OUT] sequenced synchronous active-low resets
//   busy           : high while any reset_sync_n bit is low
//   cause          : [NUM_SRC] sticky record of requesting sources
module reset_sequencer #(
    parameter int NUM_SRC     = 2,
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] reset_async_n,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] reset_sync_n,
    output logic               busy,
    output logic [NUM_SRC-1:0] cause
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;
    localparam int IDX_W  = (NUM_OUT > 1)     ? $clog2(NUM_OUT)     : 1;

    localparam int HOLD_LAST_I = HOLD_CYCLES - 1;
    localparam int GAP_LAST_I  = GAP_CYCLES - 1;
    // Index of the bit released just before the final one.
    localparam int PEN_IDX_I   = (NUM_OUT > 1) ? NUM_OUT - 2 : 0;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_LAST_I[GAP_W-1:0];
    localparam logic [IDX_W-1:0]  PEN_IDX   = PEN_IDX_I[IDX_W-1:0];

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_n;
    logic               req;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rsn_d;
    logic               busy_d;

    // Synchronizer chains: the only flops that see the raw inputs. Reset
    // loads them with 0 so the block leaves reset with a request pending and
    // runs the full release sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= reset_async_n;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];
    assign req    = ~(&sync_n);

    // State, counters and outputs are all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ASSERT;
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            reset_sync_n <= '0;
            busy         <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            reset_sync_n <= rsn_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        rsn_d      = reset_sync_n;
        busy_d     = busy;

        if (req) begin
            // Any request, in any state, drops every output in the same cycle.
            state_d    = ST_ASSERT;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
            rsn_d      = '0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    rsn_d      = '0;
                    busy_d     = 1'b1;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        // Quiet long enough: release bit 0 now.
                        rsn_d      = NUM_OUT'(1);
                        hold_cnt_d = '0;
                        gap_cnt_d  = '0;
                        idx_d      = '0;
                        if (NUM_OUT == 1) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        // Released bits form a thermometer code, so the next
                        // bit is added by shifting in a one.
                        rsn_d     = (reset_sync_n << 1) | NUM_OUT'(1);
                        gap_cnt_d = '0;
                        if (idx_q == PEN_IDX) begin
                            state_d = ST_RUN;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rsn_d  = '1;
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = ST_ASSERT;
                    rsn_d   = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    // Cause capture: a source low in the synchronized domain sets its bit,
    // and that set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause <= '0;
        end else begin
            cause <= (cause & ~{NUM_SRC{cause_clr}}) | ~sync_n;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer at default parameters. Each
//   scenario pushes the expected output transitions (edge number, value)
//   onto a queue as it drives stimulus; outputs are compared every cycle
//   against the most recently due expectation.
module tb_reset_sequencer;

    localparam int NUM_SRC     = 2;
    localparam int NUM_OUT     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_SRC-1:0] reset_async_n = 2'b11;
    logic               cause_clr = 1'b0;
    logic [NUM_OUT-1:0] reset_sync_n;
    logic               busy;
    logic [NUM_SRC-1:0] cause;

    typedef struct {
        int                 at_edge;
        logic [NUM_OUT-1:0] rsn;
        logic               busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    reset_sequencer #(
        .NUM_SRC    (NUM_SRC),
        .NUM_OUT    (NUM_OUT),
        .SYNC_STAGES(SYNC_STAGES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_async_n(reset_async_n),
        .cause_clr    (cause_clr),
        .reset_sync_n (reset_sync_n),
        .busy         (busy),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    function automatic void push_exp(int e, logic [NUM_OUT-1:0] r, logic b);
        exp_t item;
        item.at_edge = e;
        item.rsn     = r;
        item.busy    = b;
        exp_q.push_back(item);
    endfunction

    // s = edge that first samples the request low.
    function automatic void push_assert(int s);
        push_exp(s + SYNC_STAGES, '0, 1'b1);
    endfunction

    // s = edge that first samples all requests high.
    function automatic void push_release(int s);
        logic [NUM_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            r[i] = 1'b1;
            push_exp(s + SYNC_STAGES + HOLD_CYCLES + i * GAP_CYCLES, r, i != NUM_OUT - 1);
        end
    endfunction

    task automatic test_reset();
        cur.rsn  = '0;
        cur.busy = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (reset_sync_n !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_outputs edge %0d: got %b/%b want 0000/1", e, reset_sync_n, busy);
            end
            n_checks++;
            if (cause !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_cause edge %0d: got %b want 00", e, cause);
            end
        end
    endtask

    task automatic test_power_up();
        exp_q.delete();
        reset = 1'b0;
        push_release(1);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL power_up edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL power_up_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_cause_clr();
        exp_q.delete();
        cause_clr = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL cause_clr_seq edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
            if (e == 1 || e == 7 || e == 21 || e == 22) begin
                logic [NUM_SRC-1:0] want;
                want = (e == 1 || e == 22) ? 2'b00 : 2'b01;
                n_checks++;
                if (cause !== want) begin
                    n_fail++;
                    $display("FAIL cause_clr edge %0d: got %b want %b", e, cause, want);
                end
            end
            case (e)
                1: begin
                    cause_clr        = 1'b0;
                    reset_async_n[0] = 1'b0;
                    push_assert(2);
                end
                6: cause_clr = 1'b1;
                7: cause_clr = 1'b0;
                8: begin
                    reset_async_n[0] = 1'b1;
                    push_release(9);
                end
                21: cause_clr = 1'b1;
                default: ;
            endcase
        end
        cause_clr = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cause_clr_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        exp_q.delete();
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk); #1;
            if (e == 3) reset_async_n[1] = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
            if (e == 5 || e == 17) begin
                n_checks++;
                if (cause !== 2'b10) begin
                    n_fail++;
                    $display("FAIL glitch_cause edge %0d: got %b want 10", e, cause);
                end
            end
            if (e == 2) begin
                // Short low pulse straddling only edge 3.
                #8;
                reset_async_n[1] = 1'b0;
                push_assert(3);
                push_release(4);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_hold_restart();
        exp_q.delete();
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk); #1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL hold_restart edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
            case (e)
                1: begin
                    reset_async_n[0] = 1'b0;
                    push_assert(2);
                end
                4: reset_async_n[0] = 1'b1;
                // Request returns while the hold count is partway through.
                8: reset_async_n[0] = 1'b0;
                12: begin
                    reset_async_n[0] = 1'b1;
                    push_release(13);
                end
                default: ;
            endcase
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_restart_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_abort_release();
        exp_q.delete();
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL abort_release edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
            case (e)
                1: begin
                    reset_async_n[0] = 1'b0;
                    push_assert(2);
                end
                4: begin
                    reset_async_n[0] = 1'b1;
                    push_exp(11, 4'b0001, 1'b1);
                    push_exp(13, 4'b0011, 1'b1);
                end
                // Synchronized request lands between bit 1 and bit 2 releases.
                12: begin
                    reset_async_n[0] = 1'b0;
                    push_exp(15, 4'b0000, 1'b1);
                end
                16: begin
                    reset_async_n[0] = 1'b1;
                    push_release(17);
                end
                default: ;
            endcase
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_release_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_release();
        exp_q.delete();
        for (int e = 1; e <= 29; e++) begin
            @(posedge clk); #1;
            if (exp_q.size() > 0 && exp_q[0].at_edge == e) cur = exp_q.pop_front();
            n_checks++;
            if (reset_sync_n !== cur.rsn || busy !== cur.busy) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: got %b/%b want %b/%b", e, reset_sync_n, busy, cur.rsn, cur.busy);
            end
            if (e == 14 || e == 15) begin
                n_checks++;
                if (cause !== 2'b00) begin
                    n_fail++;
                    $display("FAIL reset_mid_cause edge %0d: got %b want 00", e, cause);
                end
            end
            case (e)
                1: begin
                    reset_async_n[0] = 1'b0;
                    push_assert(2);
                end
                4: begin
                    reset_async_n[0] = 1'b1;
                    push_exp(11, 4'b0001, 1'b1);
                    push_exp(13, 4'b0011, 1'b1);
                end
                13: begin
                    reset = 1'b1;
                    push_exp(14, 4'b0000, 1'b1);
                end
                15: begin
                    reset = 1'b0;
                    push_release(16);
                end
                default: ;
            endcase
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_pending: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_cause_clr();
        test_glitch();
        test_hold_restart();
        test_abort_release();
        test_reset_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
